// File: rtl/md_scheduler.sv
// -----------------------------------------------------------------------------
// md_scheduler
//
// Sequencing controller for the shared multiply/divide unit (HI/LO) in the
// E stage of a five-stage MIPS pipeline. One MD-class operation per cycle is
// accepted from E. A mult/div computes its 64-bit result in the issue cycle,
// parks it in pending registers, and a down-counter models the unit latency.
// The pending result is committed to HI/LO when the counter expires.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   E_start    in   E-stage instruction is mult/multu/div/divu
//   E_MDCtrl   in   E-stage op, [2:0]: mult, multu, div, divu, mfhi, mflo,
//                   mthi, mtlo (bit 3 unused)
//   E_MDValid  in   E-stage instruction is MD-class
//   E_A, E_B   in   forwarded rs / rt values
//   D_MD       in   D-stage instruction is MD-class
//   req        in   exception/interrupt taken; E-stage op is discarded
//   busy       out  operation in flight (count != 0)
//   stall      out  D-stage stall = D_MD && (busy || E_start)
//   HI, LO     out  committed HI / LO
//   E_MDOut    out  mfhi -> HI, anything else -> LO
// -----------------------------------------------------------------------------
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        E_start,
  input  logic [3:0]  E_MDCtrl,
  input  logic        E_MDValid,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MD,
  input  logic        req,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDOut
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MFHI  = 3'b100;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [2:0]  op;
  logic        accept;
  logic        start_go;
  logic        mt_go;

  logic [3:0]  count;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        div0;

  assign op       = E_MDCtrl[2:0];
  assign busy     = (count != 4'd0);
  assign stall    = D_MD && (busy || E_start);
  assign E_MDOut  = (op == OP_MFHI) ? HI : LO;

  // An op only takes effect when the unit is free and no exception squashes it.
  assign accept   = E_MDValid && !req && !busy;
  assign start_go = accept && E_start;
  assign mt_go    = accept && !E_start && (op[2:1] == 2'b11);

  // ---------------------------------------------------------------------------
  // Datapath: one 33x33 signed multiplier covers mult and multu (operands are
  // sign- or zero-extended by one bit). One unsigned divider covers div and
  // divu; signed division works on magnitudes and fixes signs afterwards, so
  // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  // ---------------------------------------------------------------------------
  logic               mul_signed;
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [65:0] mul_p;

  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        div_den;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        quot;
  logic [31:0]        rem;

  logic [1:0]         unused_mul_top;
  logic               unused_ctrl_bit;

  assign mul_signed = (op == OP_MULT);
  assign mul_a      = {mul_signed & E_A[31], E_A};
  assign mul_b      = {mul_signed & E_B[31], E_B};
  assign mul_p      = mul_a * mul_b;

  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & E_A[31];
  assign b_neg      = div_signed & E_B[31];
  assign a_mag      = a_neg ? (32'd0 - E_A) : E_A;
  assign b_mag      = b_neg ? (32'd0 - E_B) : E_B;
  // Divisor zero never commits; feed 1 so the divider never sees a zero.
  assign div_den    = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / div_den;
  assign r_mag      = a_mag % div_den;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  assign unused_mul_top  = mul_p[65:64];
  assign unused_ctrl_bit = E_MDCtrl[3];

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_div0;
  logic [3:0]  res_cycles;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    res_hi     = mul_p[63:32];
    res_lo     = mul_p[31:0];
    res_div0   = 1'b0;
    res_cycles = MULT_LOAD;
    case (op)
      OP_MULT, OP_MULTU: begin
        res_hi     = mul_p[63:32];
        res_lo     = mul_p[31:0];
        res_cycles = MULT_LOAD;
      end
      OP_DIV, OP_DIVU: begin
        res_hi     = rem;
        res_lo     = quot;
        res_div0   = (E_B == 32'd0);
        res_cycles = DIV_LOAD;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State: count==0 is IDLE, count!=0 is BUSY. The commit happens on the edge
  // where count steps 1 -> 0. mt writes and commits are mutually exclusive
  // because mt is only accepted while idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      div0    <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments here, so every register in this block
      // samples the pre-edge values regardless of statement order.
      if (start_go) begin
        count   <= res_cycles;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        div0    <= res_div0;
      end else if (busy) begin
        count <= count - 4'd1;
        if (count == 4'd1) begin
          if (!div0) begin
            HI <= pend_hi;
            LO <= pend_lo;
          end
          div0 <= 1'b0;
        end
      end

      if (mt_go) begin
        if (op[0]) LO <= E_A;
        else       HI <= E_A;
      end
    end
  end

  // The D-stage stall keeps new starts and mt writes away from a busy unit.
  a_no_issue_while_busy : assert property (
    @(posedge clk) disable iff (!reset_n)
      busy |-> !(E_MDValid && (E_start || (op[2:1] == 2'b11)))
  );

endmodule

// File: tb/tb_md_scheduler.sv
// -----------------------------------------------------------------------------
// tb_md_scheduler
//
// Directed bench for md_scheduler. A timestamp-based reference model (results
// from 64-bit integer arithmetic, commit scheduled at an absolute edge number)
// is compared against all outputs on every falling edge; directed sequences
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_md_scheduler;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MFHI  = 3'b100;
  localparam logic [2:0] MFLO  = 3'b101;
  localparam logic [2:0] MTHI  = 3'b110;
  localparam logic [2:0] MTLO  = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        E_start;
  logic [3:0]  E_MDCtrl;
  logic        E_MDValid;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_MD;
  logic        req;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDOut;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  md_scheduler #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .E_start   (E_start),
    .E_MDCtrl  (E_MDCtrl),
    .E_MDValid (E_MDValid),
    .E_A       (E_A),
    .E_B       (E_B),
    .D_MD      (D_MD),
    .req       (req),
    .busy      (busy),
    .stall     (stall),
    .HI        (HI),
    .LO        (LO),
    .E_MDOut   (E_MDOut)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  bit          p_div0 = 1'b0;
  bit          m_busy = 1'b0;
  int          edge_k = 0;
  int          commit_edge = 0;

  function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi,
                                   output logic [31:0] lo, output bit dz);
    int              ia = a;
    int              ib = b;
    longint          sa = ia;
    longint          sb = ib;
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          sp;
    longint unsigned up;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      DIV:   if (sb == 0) dz = 1'b1;
             else begin sp = sa / sb; lo = sp[31:0]; sp = sa % sb; hi = sp[31:0]; end
      DIVU:  if (ub == 0) dz = 1'b1;
             else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
      default: ;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_div0 = 1'b0; m_busy = 1'b0;
    end else begin
      edge_k++;
      if (m_busy) begin
        if (edge_k == commit_edge) begin
          if (!p_div0) begin m_hi = p_hi; m_lo = p_lo; end
          m_busy = 1'b0;
        end
      end else if (E_MDValid && !req) begin
        if (E_start) begin
          model_op(E_MDCtrl[2:0], E_A, E_B, p_hi, p_lo, p_div0);
          commit_edge = edge_k + (E_MDCtrl[1] ? DIV_N : MULT_N);
          m_busy = 1'b1;
        end else if (E_MDCtrl[2:0] == MTHI) m_hi = E_A;
        else if (E_MDCtrl[2:0] == MTLO) m_lo = E_A;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_busy",  {31'd0, busy},  {31'd0, m_busy});
    check("cmp_stall", {31'd0, stall}, {31'd0, D_MD && (m_busy || E_start)});
    check("cmp_hi", HI, m_hi);
    check("cmp_lo", LO, m_lo);
    check("cmp_mdout", E_MDOut, (E_MDCtrl[2:0] == MFHI) ? m_hi : m_lo);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic idle();
    E_start = 1'b0; E_MDValid = 1'b0; E_MDCtrl = 4'd0; req = 1'b0;
    #1;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic r);
    E_MDCtrl  = {1'b1, op};
    E_start   = (op[2] == 1'b0);
    E_MDValid = 1'b1;
    E_A = a; E_B = b; req = r;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
    drive_op(op, a, b, r);
    step();
    idle();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) step();
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[3] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[5] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};

    reset_n = 1'b0; D_MD = 1'b0; E_A = '0; E_B = '0;
    idle();
    repeat (3) step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset_n = 1'b1;
    step();

    // mult -3 * 5
    issue(MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
    for (int i = 1; i <= MULT_N; i++) begin
      check("mult_busy", {31'd0, busy}, 32'd1);
      check("mult_hi_old", HI, 32'd0);
      check("mult_lo_old", LO, 32'd0);
      step();
    end
    check("mult_busy_done", {31'd0, busy}, 32'd0);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFF1);

    // multu same operands
    issue(MULTU, 32'hFFFFFFFD, 32'd5, 1'b0);
    repeat (MULT_N) step();
    check("multu_busy_done", {31'd0, busy}, 32'd0);
    check("multu_hi", HI, 32'h00000004);
    check("multu_lo", LO, 32'hFFFFFFF1);

    // div -7 / 2 with a D-stage MD instruction waiting
    D_MD = 1'b1;
    drive_op(DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_stall_T", {31'd0, stall}, 32'd1);
    step();
    idle();
    for (int i = 1; i <= DIV_N; i++) begin
      check("div_stall_busy", {31'd0, stall}, 32'd1);
      step();
    end
    check("div_stall_released", {31'd0, stall}, 32'd0);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);
    D_MD = 1'b0;

    // mt / mf, then divide by zero leaves HI/LO alone
    issue(MTHI, 32'h00001234, 32'd0, 1'b0);
    check("mthi", HI, 32'h00001234);
    issue(MTLO, 32'h00005678, 32'd0, 1'b0);
    check("mtlo", LO, 32'h00005678);
    drive_op(MFLO, 32'd0, 32'd0, 1'b0);
    check("mflo", E_MDOut, 32'h00005678);
    drive_op(MFHI, 32'd0, 32'd0, 1'b0);
    check("mfhi", E_MDOut, 32'h00001234);
    step();
    idle();
    issue(DIVU, 32'd99, 32'd0, 1'b0);
    for (int i = 1; i <= DIV_N; i++) begin
      check("div0_busy", {31'd0, busy}, 32'd1);
      step();
    end
    check("div0_busy_done", {31'd0, busy}, 32'd0);
    check("div0_hi", HI, 32'h00001234);
    check("div0_lo", LO, 32'h00005678);

    // req squashes E-stage ops
    issue(MULT, 32'd3, 32'd4, 1'b1);
    check("req_busy", {31'd0, busy}, 32'd0);
    check("req_hi", HI, 32'h00001234);
    check("req_lo", LO, 32'h00005678);
    issue(MTHI, 32'hDEADBEEF, 32'd0, 1'b1);
    check("req_mthi", HI, 32'h00001234);

    // req during BUSY does not stop the in-flight mult
    issue(MULT, 32'd3, 32'd4, 1'b0);
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    repeat (2) step();
    check("req_mid_busy", {31'd0, busy}, 32'd1);
    check("req_mid_lo_old", LO, 32'h00005678);
    step();
    check("req_mid_done", {31'd0, busy}, 32'd0);
    check("req_mid_hi", HI, 32'd0);
    check("req_mid_lo", LO, 32'd12);

    // reset in the middle of a div
    issue(DIV, 32'd100, 32'd7, 1'b0);
    repeat (2) step();
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    step();
    reset_n = 1'b1;
    repeat (12) step();
    check("arst_no_commit_busy", {31'd0, busy}, 32'd0);
    check("arst_no_commit_hi", HI, 32'd0);
    check("arst_no_commit_lo", LO, 32'd0);
    issue(MTLO, 32'hA5A5A5A5, 32'd0, 1'b0);
    check("arst_mtlo", LO, 32'hA5A5A5A5);

    // boundary operand table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      wait_idle();
      check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
    end

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Sequencing controller for the shared multiply/divide resource (HI/LO) in the E stage of the five-stage MIPS pipeline. It accepts one mult/multu/div/divu/mfhi/mflo/mthi/mtlo operation per cycle from E. It models the multi-cycle latency with a busy counter and commits results to HI/LO. It raises the D-stage stall for any MD-class instruction while the unit is occupied, and squashes E-stage operations when an exception/interrupt request is taken.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- E_start  in  1  E-stage instruction is mult/multu/div/divu
- E_MDCtrl  in  4  E-stage op; bit 3 ignored; [2:0]: 000 mult, 001 multu, 010 div, 011 divu, 100 mfhi, 101 mflo, 110 mthi, 111 mtlo
- E_MDValid  in  1  E-stage instruction is MD-class (start, mf or mt)
- E_A  in  32  forwarded rs value
- E_B  in  32  forwarded rt value
- D_MD  in  1  D-stage instruction is MD-class
- req  in  1  exception/interrupt taken this cycle; E-stage op must not take effect
- busy  out  1  operation in flight
- stall  out  1  D-stage stall request = D_MD && (busy || E_start)
- HI  out  32  committed HI
- LO  out  32  committed LO
- E_MDOut  out  32  mfhi -> HI, otherwise LO (combinational)

## Operation
- State: IDLE (count==0) / BUSY (count!=0), 4-bit down-counter `count`, 32-bit pending HI/LO, 1-bit div0 flag.
- Accept condition: E_MDValid && !req && !busy.
- Start accepted: load count with MULT_CYCLES or DIV_CYCLES. Compute the result from E_A/E_B this cycle and latch it into the pending registers.
  - mult: signed 64-bit product; HI=[63:32], LO=[31:0].
  - multu: unsigned 64-bit product.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with sign of dividend. 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned.
  - Divisor 0 (div/divu): set div0; HI/LO are left unchanged at commit.
- BUSY: count decrements each cycle. On the edge where count goes 1->0, pending is copied to HI/LO unless div0, and div0 is cleared.
- mthi/mtlo accepted: HI or LO := E_A on the same edge; no busy.
- mfhi/mflo: no state change; E_MDOut is valid combinationally.
- E_start or mt while busy: ignored. Stall logic makes this unreachable; it is an assertion target.
- req with an E-stage MD op: op discarded. No count load, no HI/LO write.
- req during BUSY: in-flight operation belongs to an older instruction; it continues and commits normally.
- Reset: HI=0, LO=0, count=0, div0=0, pending=0; busy=0, stall follows inputs. Reset mid-operation abandons the result.

## Timing
- Start accepted in cycle T: busy=1 in T+1..T+N (N = MULT_CYCLES or DIV_CYCLES). HI/LO hold the new value from T+N+1.
- busy is a registered output (count!=0); stall is combinational.
- D-stage MD instruction is stalled in T (via E_start) and T+1..T+N (via busy). It enters E at T+N+1 and sees committed HI/LO.
- mt at T: new HI/LO visible from T+1. mf immediately following in the next cycle reads the new value.
- Back-to-back start is impossible: the second start is stalled in D until busy drops.
- Non-MD D-stage instructions never stall on this block.

## Test plan
- mult E_A=0xFFFFFFFD, E_B=5 at T:
  - busy high T+1..T+5, low T+6.
  - HI/LO old values through T+5.
  - HI=0xFFFFFFFF, LO=0xFFFFFFF1 at T+6.
- multu with the same operands: HI=0x00000004, LO=0xFFFFFFF1 after 5 busy cycles.
- div E_A=0xFFFFFFF9 (-7), E_B=2:
  - 10 busy cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - D_MD=1 throughout gives stall=1 from T to T+10 and 0 at T+11.
- Divide by zero:
  - mthi 0x1234, mtlo 0x5678, then divu with E_B=0.
  - busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
- req asserted with E_start (mult 3*4) at T:
  - busy stays 0; HI/LO unchanged.
  - Separately, req asserted at T+2 of a running mult: commit still occurs at T+6.
- reset_n pulsed low at T+3 of a div:
  - busy, HI, LO and count go to 0 immediately (asynchronously).
  - No commit after reset is released.
  - A subsequent mtlo 0xA5A5A5A5 is visible on LO the next cycle.
